// File: rtl/alu_pipe.sv
// alu_pipe -- pipelined integer ALU for the execute stage.
//
// Takes one operation per cycle from the reservation station. It computes
// arithmetic, logic, shift, compare and branch-condition results in stage 0,
// then moves them through STAGES result registers using an elastic
// valid/advance handshake. The last stage presents a CDB packet and holds it
// until the CDB takes it with yumi_in. A flush kills every in-flight entry.
//
// Ports
//   clk              : clock, all state on rising edge
//   reset            : asynchronous, active-low reset
//   valid_in/ready   : operation handshake (transfer = valid_in & ready)
//   alu_op           : 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLTU 7 SLL 8 SRL 9 SRA
//   branch_type      : 0 none 1 BEQ 2 BNE 3 BLT 4 BGE 5 BLTU 6 BGEU
//   rs1, rs2         : operands
//   rs_rob_entry     : destination ROB tag
//   flush            : drop all in-flight ops and this cycle's input
//   valid_out/yumi_in: head result valid / CDB consumes head
//   out_*            : CDB packet, zero while valid_out is low
//   inflight         : number of valid entries in the pipe
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int ROB_W  = 4,
    parameter int STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            valid_in,
    output logic                            ready,
    input  logic [3:0]                      alu_op,
    input  logic [2:0]                      branch_type,
    input  logic [WIDTH-1:0]                rs1,
    input  logic [WIDTH-1:0]                rs2,
    input  logic [ROB_W-1:0]                rs_rob_entry,
    input  logic                            flush,
    output logic                            valid_out,
    input  logic                            yumi_in,
    output logic [ROB_W-1:0]                out_rob,
    output logic [WIDTH-1:0]                out_result,
    output logic                            out_branch_taken,
    output logic                            out_from_memory,
    output logic [$clog2(STAGES+1)-1:0]     inflight
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(STAGES+1);
    localparam int LAST  = STAGES - 1;

    // ------------------------------------------------------------------
    // Stage-0 compute
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] diff;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;
    logic             flag_z;
    logic             carry_into_msb;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_c;
    logic             taken_c;

    // SUB, compares and branches all share one rs1 + ~rs2 + 1 adder so that
    // the flags are consistent across the three uses.
    assign sub_full = {1'b0, rs1} + {1'b0, ~rs2} + {{WIDTH{1'b0}}, 1'b1};
    assign diff     = sub_full[WIDTH-1:0];
    assign flag_c   = sub_full[WIDTH];
    assign flag_n   = diff[WIDTH-1];
    assign flag_z   = (diff == '0);
    // Carry into the MSB is recovered from the MSB sum bit and its addends.
    assign carry_into_msb = diff[WIDTH-1] ^ rs1[WIDTH-1] ^ ~rs2[WIDTH-1];
    assign flag_v   = carry_into_msb ^ flag_c;
    assign shamt    = rs2[SHW-1:0];

    always_comb begin
        res_c   = '0;
        taken_c = 1'b0;
        if (branch_type != 3'd0) begin
            res_c = diff;
            case (branch_type)
                3'd1:    taken_c = flag_z;
                3'd2:    taken_c = ~flag_z;
                3'd3:    taken_c = flag_n ^ flag_v;
                3'd4:    taken_c = ~(flag_n ^ flag_v);
                3'd5:    taken_c = ~flag_c;
                3'd6:    taken_c = flag_c;
                default: taken_c = 1'b0;
            endcase
        end else begin
            case (alu_op)
                4'd0:    res_c = rs1 + rs2;
                4'd1:    res_c = diff;
                4'd2:    res_c = rs1 & rs2;
                4'd3:    res_c = rs1 | rs2;
                4'd4:    res_c = rs1 ^ rs2;
                4'd5:    res_c = {{(WIDTH-1){1'b0}}, flag_n ^ flag_v};
                4'd6:    res_c = {{(WIDTH-1){1'b0}}, ~flag_c};
                4'd7:    res_c = rs1 << shamt;
                4'd8:    res_c = rs1 >> shamt;
                4'd9:    res_c = $unsigned($signed(rs1) >>> shamt);
                default: res_c = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Elastic pipeline
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q, valid_d;
    logic [ROB_W-1:0]  rob_q [STAGES];
    logic [ROB_W-1:0]  rob_d [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [STAGES-1:0] tkn_q, tkn_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;

    logic [STAGES:0]   free;
    logic [STAGES-1:0] adv;
    logic              accept;
    logic              yumi_eff;

    // free[i] means stage i can take a new entry this cycle. It is evaluated
    // from the head backwards, so a yumi on a full pipe ripples all the way
    // to ready in the same cycle.
    always_comb begin
        free         = '0;
        adv          = '0;
        free[STAGES] = yumi_in;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i]  = valid_q[i] & free[i+1];
            free[i] = ~valid_q[i] | adv[i];
        end
    end

    assign ready    = free[0];
    assign accept   = valid_in & free[0];
    assign yumi_eff = yumi_in & valid_q[LAST];

    always_comb begin
        valid_d = valid_q;
        rob_d   = rob_q;
        res_d   = res_q;
        tkn_d   = tkn_q;

        valid_d[0] = accept | (valid_q[0] & ~adv[0]);
        if (accept) begin
            rob_d[0] = rs_rob_entry;
            res_d[0] = res_c;
            tkn_d[0] = taken_c;
        end

        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = adv[i-1] | (valid_q[i] & ~adv[i]);
            if (adv[i-1]) begin
                rob_d[i] = rob_q[i-1];
                res_d[i] = res_q[i-1];
                tkn_d[i] = tkn_q[i-1];
            end
        end

        // Payload may still load on a flush cycle; only the valid bits matter.
        if (flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (accept && !yumi_eff) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && yumi_eff) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            tkn_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                rob_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            tkn_q      <= tkn_d;
            inflight_q <= inflight_d;
            for (int i = 0; i < STAGES; i++) begin
                rob_q[i] <= rob_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // CDB packet. Stale payload in an empty head stage is masked to zero.
    // ------------------------------------------------------------------
    assign valid_out        = valid_q[LAST];
    assign out_rob          = valid_q[LAST] ? rob_q[LAST] : '0;
    assign out_result       = valid_q[LAST] ? res_q[LAST] : '0;
    assign out_branch_taken = valid_q[LAST] & tkn_q[LAST];
    assign out_from_memory  = 1'b0;
    assign inflight         = inflight_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready;
    logic [3:0]  alu_op;
    logic [2:0]  branch_type;
    logic [31:0] rs1, rs2;
    logic [3:0]  rs_rob_entry;
    logic        flush;
    logic        valid_out;
    logic        yumi_in;
    logic [3:0]  out_rob;
    logic [31:0] out_result;
    logic        out_branch_taken;
    logic        out_from_memory;
    logic [1:0]  inflight;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .ROB_W(4), .STAGES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .ready            (ready),
        .alu_op           (alu_op),
        .branch_type      (branch_type),
        .rs1              (rs1),
        .rs2              (rs2),
        .rs_rob_entry     (rs_rob_entry),
        .flush            (flush),
        .valid_out        (valid_out),
        .yumi_in          (yumi_in),
        .out_rob          (out_rob),
        .out_result       (out_result),
        .out_branch_taken (out_branch_taken),
        .out_from_memory  (out_from_memory),
        .inflight         (inflight)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] br,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        valid_in     = v;
        alu_op       = op;
        branch_type  = br;
        rs1          = a;
        rs2          = b;
        rs_rob_entry = tag;
    endtask

    // Streaming vectors: op, branch type, operands, expected result/taken.
    localparam int NV = 14;
    logic [3:0]  s_op  [NV];
    logic [2:0]  s_br  [NV];
    logic [31:0] s_a   [NV];
    logic [31:0] s_b   [NV];
    logic [31:0] s_res [NV];
    logic        s_tkn [NV];

    initial begin
        s_op[0]=4'd1;  s_br[0]=3'd0;  s_a[0]=32'h3;        s_b[0]=32'h5;        s_res[0]=32'hFFFF_FFFE; s_tkn[0]=1'b0;
        s_op[1]=4'd5;  s_br[1]=3'd0;  s_a[1]=32'hFFFF_FFFF; s_b[1]=32'h1;       s_res[1]=32'h1;         s_tkn[1]=1'b0;
        s_op[2]=4'd6;  s_br[2]=3'd0;  s_a[2]=32'h1;        s_b[2]=32'hFFFF_FFFF; s_res[2]=32'h1;        s_tkn[2]=1'b0;
        s_op[3]=4'd9;  s_br[3]=3'd0;  s_a[3]=32'h8000_0000; s_b[3]=32'h4;       s_res[3]=32'hF800_0000; s_tkn[3]=1'b0;
        s_op[4]=4'd4;  s_br[4]=3'd0;  s_a[4]=32'hF0F0_F0F0; s_b[4]=32'hFF00_FF00; s_res[4]=32'h0FF0_0FF0; s_tkn[4]=1'b0;
        s_op[5]=4'd7;  s_br[5]=3'd0;  s_a[5]=32'h1;        s_b[5]=32'h3F;       s_res[5]=32'h8000_0000; s_tkn[5]=1'b0;
        s_op[6]=4'd8;  s_br[6]=3'd0;  s_a[6]=32'h8000_0000; s_b[6]=32'h24;      s_res[6]=32'h0800_0000; s_tkn[6]=1'b0;
        s_op[7]=4'd12; s_br[7]=3'd0;  s_a[7]=32'h5;        s_b[7]=32'h6;        s_res[7]=32'h0;         s_tkn[7]=1'b0;
        s_op[8]=4'd2;  s_br[8]=3'd3;  s_a[8]=32'h8000_0000; s_b[8]=32'h1;       s_res[8]=32'h7FFF_FFFF; s_tkn[8]=1'b1;
        s_op[9]=4'd0;  s_br[9]=3'd6;  s_a[9]=32'h8000_0000; s_b[9]=32'h1;       s_res[9]=32'h7FFF_FFFF; s_tkn[9]=1'b1;
        s_op[10]=4'd0; s_br[10]=3'd1; s_a[10]=32'h7;       s_b[10]=32'h7;       s_res[10]=32'h0;        s_tkn[10]=1'b1;
        s_op[11]=4'd0; s_br[11]=3'd2; s_a[11]=32'h7;       s_b[11]=32'h7;       s_res[11]=32'h0;        s_tkn[11]=1'b0;
        s_op[12]=4'd0; s_br[12]=3'd7; s_a[12]=32'h7;       s_b[12]=32'h7;       s_res[12]=32'h0;        s_tkn[12]=1'b0;
        s_op[13]=4'd0; s_br[13]=3'd5; s_a[13]=32'h1;       s_b[13]=32'h2;       s_res[13]=32'hFFFF_FFFF; s_tkn[13]=1'b1;
    end

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        yumi_in = 1'b0;
        drive(1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 4'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid_out", {31'b0, valid_out}, 32'h0);
        chk("rst_ready",     {31'b0, ready}, 32'h1);
        chk("rst_inflight",  {30'b0, inflight}, 32'h0);
        chk("rst_result",    out_result, 32'h0);
        chk("rst_rob",       {28'b0, out_rob}, 32'h0);
        chk("rst_from_mem",  {31'b0, out_from_memory}, 32'h0);

        // Single ADD, latency STAGES-1 cycles after the accept edge
        reset = 1'b1;
        drive(1'b1, 4'd0, 3'd0, 32'h7FFF_FFFF, 32'h1, 4'd5);
        #1 chk("add_ready_first", {31'b0, ready}, 32'h1);
        @(negedge clk);
        drive(1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 4'd0);
        chk("add_not_yet",   {31'b0, valid_out}, 32'h0);
        chk("add_inflight1", {30'b0, inflight}, 32'h1);
        @(negedge clk);
        chk("add_valid",  {31'b0, valid_out}, 32'h1);
        chk("add_result", out_result, 32'h8000_0000);
        chk("add_rob",    {28'b0, out_rob}, 32'h5);
        chk("add_taken",  {31'b0, out_branch_taken}, 32'h0);
        yumi_in = 1'b1;
        @(negedge clk);
        yumi_in = 1'b0;
        chk("add_drained",  {31'b0, valid_out}, 32'h0);
        chk("add_inflight0", {30'b0, inflight}, 32'h0);

        // Back-to-back stream with yumi held high
        yumi_in = 1'b1;
        for (int k = 0; k < NV + 2; k++) begin
            if (k >= 2) begin
                chk("stream_valid",  {31'b0, valid_out}, 32'h1);
                chk("stream_result", out_result, s_res[k-2]);
                chk("stream_taken",  {31'b0, out_branch_taken}, {31'b0, s_tkn[k-2]});
                chk("stream_rob",    {28'b0, out_rob}, 32'(k-2));
            end
            if (k < NV) drive(1'b1, s_op[k], s_br[k], s_a[k], s_b[k], 4'(k));
            else        drive(1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 4'd0);
            @(negedge clk);
        end
        chk("stream_empty", {31'b0, valid_out}, 32'h0);
        yumi_in = 1'b0;

        // Backpressure
        drive(1'b1, 4'd0, 3'd0, 32'd1, 32'd2, 4'd1);
        @(negedge clk);
        chk("bp_ready_after1", {31'b0, ready}, 32'h1);
        drive(1'b1, 4'd0, 3'd0, 32'd10, 32'd20, 4'd2);
        @(negedge clk);
        drive(1'b1, 4'd0, 3'd0, 32'd100, 32'd200, 4'd3);
        #1;
        chk("bp_ready_full", {31'b0, ready}, 32'h0);
        chk("bp_inflight2",  {30'b0, inflight}, 32'h2);
        chk("bp_head_rob",   {28'b0, out_rob}, 32'h1);
        chk("bp_head_res",   out_result, 32'd3);
        @(negedge clk);
        chk("bp_held_rob",   {28'b0, out_rob}, 32'h1);
        chk("bp_held_ready", {31'b0, ready}, 32'h0);
        chk("bp_held_infl",  {30'b0, inflight}, 32'h2);
        yumi_in = 1'b1;
        #1 chk("bp_passthru_ready", {31'b0, ready}, 32'h1);
        @(negedge clk);
        yumi_in = 1'b0;
        drive(1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 4'd0);
        chk("bp_second_rob", {28'b0, out_rob}, 32'h2);
        chk("bp_second_res", out_result, 32'd30);
        chk("bp_second_infl", {30'b0, inflight}, 32'h2);
        @(negedge clk);
        chk("bp_second_held", {28'b0, out_rob}, 32'h2);
        yumi_in = 1'b1;
        @(negedge clk);
        chk("bp_third_rob",  {28'b0, out_rob}, 32'h3);
        chk("bp_third_res",  out_result, 32'd300);
        chk("bp_third_infl", {30'b0, inflight}, 32'h1);
        @(negedge clk);
        yumi_in = 1'b0;
        chk("bp_empty",      {31'b0, valid_out}, 32'h0);
        chk("bp_empty_infl", {30'b0, inflight}, 32'h0);

        // Flush with a full pipe and a simultaneous input
        drive(1'b1, 4'd0, 3'd0, 32'd1, 32'd1, 4'd1);
        @(negedge clk);
        drive(1'b1, 4'd0, 3'd0, 32'd2, 32'd2, 4'd2);
        @(negedge clk);
        chk("fl_full_infl", {30'b0, inflight}, 32'h2);
        flush   = 1'b1;
        yumi_in = 1'b1;
        drive(1'b1, 4'd0, 3'd0, 32'd5, 32'd5, 4'd9);
        @(negedge clk);
        flush   = 1'b0;
        yumi_in = 1'b0;
        drive(1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 4'd0);
        chk("fl_valid_out", {31'b0, valid_out}, 32'h0);
        chk("fl_inflight",  {30'b0, inflight}, 32'h0);
        chk("fl_ready",     {31'b0, ready}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fl_no_ghost", {31'b0, valid_out}, 32'h0);
        end

        // Asynchronous reset mid-operation
        drive(1'b1, 4'd0, 3'd0, 32'd3, 32'd3, 4'd4);
        @(negedge clk);
        drive(1'b1, 4'd0, 3'd0, 32'd4, 32'd4, 4'd6);
        @(negedge clk);
        drive(1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 4'd0);
        chk("ar_pre_valid", {31'b0, valid_out}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid_out", {31'b0, valid_out}, 32'h0);
        chk("ar_result",    out_result, 32'h0);
        chk("ar_rob",       {28'b0, out_rob}, 32'h0);
        chk("ar_inflight",  {30'b0, inflight}, 32'h0);
        chk("ar_ready",     {31'b0, ready}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 4'd0, 3'd0, 32'd1, 32'd1, 4'd7);
        @(negedge clk);
        drive(1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        chk("ar_new_valid",  {31'b0, valid_out}, 32'h1);
        chk("ar_new_result", out_result, 32'd2);
        chk("ar_new_rob",    {28'b0, out_rob}, 32'h7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer ALU functional unit for the execute stage. It accepts one operation per cycle from its reservation station and computes arithmetic, logic, shift, compare and branch-condition results over a configurable number of register stages. It holds results under CDB backpressure (valid/yumi) and supports a global flush. Each output beat carries its ROB tag, result and branch outcome for broadcast on the CDB.

## Interface
- `WIDTH`, 32: operand/result width; ≥8, power of two.
- `ROB_W`, 4: ROB tag width.
- `STAGES`, 2: pipeline depth (result registers), ≥1.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `valid_in` in 1: operation presented.
- `ready` out 1: unit accepts this cycle; transfer = `valid_in & ready`.
- `alu_op` in 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10–15 reserved (result 0).
- `branch_type` in 3: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved (not taken).
- `rs1`, `rs2` in WIDTH: operands.
- `rs_rob_entry` in ROB_W: destination ROB tag.
- `flush` in 1: kill every in-flight operation.
- `valid_out` out 1: head result valid.
- `yumi_in` in 1: CDB takes head result this cycle; legal only while `valid_out`=1.
- `out_rob` out ROB_W, `out_result` out WIDTH, `out_branch_taken` out 1, `out_from_memory` out 1 (constant 0): CDB packet fields.
- `inflight` out $clog2(STAGES+1): count of valid entries in the pipe.

## Operation
- Stage 0 computes combinationally from inputs and registers into stage-0 register. Stages 1..STAGES-1 are plain holding registers. The last stage drives the outputs.
- Arithmetic: SUB and all branches use rs1 + ~rs2 + 1 over WIDTH bits. Carry-out, overflow (carry into MSB XOR carry out), negative (MSB) and zero are taken from that sum.
- SLT: result 1 iff (negative ^ overflow). SLTU: result 1 iff no carry-out. Results are zero-extended to WIDTH.
- Shifts use `rs2[$clog2(WIDTH)-1:0]`. SRA replicates `rs1[WIDTH-1]`.
- When `branch_type`≠0, `alu_op` is ignored and `out_result` = rs1−rs2.
- Branch taken: BEQ zero; BNE ~zero; BLT n^v; BGE ~(n^v); BLTU ~carry; BGEU carry. When `branch_type`=0, `out_branch_taken`=0.
- Elastic pipeline. Stage i advances when it is valid and stage i+1 is empty or advancing. The last stage advances on `yumi_in`.
- `ready` = stage 0 empty or stage 0 advancing. It is combinational and independent of `valid_in`.
- Flush: on an edge with `flush`=1, all valid bits are cleared and that cycle's `valid_in` is dropped. Flush overrides accept and yumi.
- `inflight` is updated every edge: +1 on accept, −1 on yumi, both or neither → unchanged, 0 after flush.
- Payload registers load only on advance. Invalid stages hold stale payload, but output fields read 0 while `valid_out`=0.

## Timing
- Reset (asynchronous, while low): `valid_out`=0, `out_rob`=0, `out_result`=0, `out_branch_taken`=0, `out_from_memory`=0, `inflight`=0, `ready`=1.
- Latency: an op accepted at edge N has `valid_out`=1 after edge N+STAGES-1, i.e. in the cycle following that edge, when there is no stall.
- Throughput: 1 op/cycle with `yumi_in` held high. Full occupancy is STAGES entries.
- Full pipe with `yumi_in`=0: `ready`=0 and the head is held stable.
- Full pipe with `yumi_in`=1: `ready`=1 in the same cycle (pass-through accept).
- `yumi_in` while `valid_out`=0: ignored.
- Reset asserted mid-operation discards all entries. The first accept after release is legal in the first cycle `reset` is high.

## Test plan
- Reset then ADD 0x7FFFFFFF+1, tag 5, STAGES=2 → `valid_out` one cycle after the accept edge, `out_result`=0x80000000, `out_rob`=5, `out_branch_taken`=0.
- Back-to-back SUB 3−5, SLT −1<1, SLTU 1<0xFFFFFFFF, SRA 0x80000000>>>4 with `yumi_in`=1 → results in order: 0xFFFFFFFE, 1, 1, 0xF8000000, one per cycle.
- Branches: BLT rs1=0x80000000, rs2=1 → taken. BGEU with the same operands → taken. BEQ 7,7 → taken. BNE 7,7 → not taken.
- Backpressure: 3 accepts with `yumi_in`=0 (STAGES=2) → `ready` drops after 2 accepts, `inflight`=2, head is held. Pulsing `yumi_in` drains the results in order.
- Flush with a full pipe and `valid_in`=1 in the same cycle → next cycle `valid_out`=0, `inflight`=0, `ready`=1, and the dropped op never appears.
- `reset` asserted low between clock edges with 2 in flight → outputs zero immediately. After release, a new ADD 1+1 → `out_result`=2.
